// File: rtl/a25_wb_sram_slave.sv
// ============================================================================
// Module   : a25_wb_sram_slave
// Purpose  : Wishbone SRAM slave with wait states and out-of-range error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module a25_wb_sram_slave #(
    parameter int WB_DWIDTH   = 128,
    parameter int WB_SWIDTH   = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk,
    input  logic                  quick_n_reset,
    input  logic [31:0]           i_wb_adr,
    input  logic [WB_SWIDTH-1:0]  i_wb_sel,
    input  logic                  i_wb_we,
    input  logic [WB_DWIDTH-1:0]  i_wb_dat,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    output logic [WB_DWIDTH-1:0]  o_wb_dat,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic                  o_busy
);

    localparam int c_LSB     = $clog2(WB_SWIDTH);
    localparam bit c_NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [DEPTH_LOG2-1:0]  r_index;
    logic                   r_in_range;
    logic                   r_we;
    logic [WB_SWIDTH-1:0]   r_sel;
    logic [WB_DWIDTH-1:0]   r_dat;
    logic [WB_DWIDTH-1:0]   r_mem [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0]  w_in_index;
    logic                   w_in_range_in;
    logic                   w_idle;
    logic [DEPTH_LOG2-1:0]  w_index;
    logic                   w_in_range;
    logic                   w_we;
    logic [WB_SWIDTH-1:0]   w_sel;
    logic [WB_DWIDTH-1:0]   w_dat;
    logic                   w_fire;
    logic                   w_wr_en;
    logic                   w_unused;

    assign w_in_index    = i_wb_adr[c_LSB +: DEPTH_LOG2];
    assign w_in_range_in = (i_wb_adr[31:c_LSB+DEPTH_LOG2] == '0);
    assign w_unused      = &{1'b0, i_wb_adr[c_LSB-1:0]};

    // Zero-wait beats respond on the sampling edge itself, so use live inputs in S_IDLE.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_index    = w_idle ? w_in_index    : r_index;
        w_in_range = w_idle ? w_in_range_in : r_in_range;
        w_we       = w_idle ? i_wb_we       : r_we;
        w_sel      = w_idle ? i_wb_sel      : r_sel;
        w_dat      = w_idle ? i_wb_dat      : r_dat;
        w_fire     = (w_idle && c_NO_WAIT && i_wb_cyc && i_wb_stb) ||
                     ((r_state == S_WAIT) && i_wb_cyc && (r_cnt == 4'd0));
        w_wr_en    = quick_n_reset && w_fire && w_we && w_in_range;
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < WB_SWIDTH; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_index][i*8 +: 8] <= w_dat[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge quick_n_reset) begin
        if (!quick_n_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_index    <= '0;
            r_in_range <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_dat      <= '0;
            o_wb_dat   <= '0;
            o_wb_ack   <= 1'b0;
            o_wb_err   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            if (w_fire) begin
                o_wb_ack <= w_in_range;
                o_wb_err <= !w_in_range;
                if (w_in_range && !w_we) begin
                    o_wb_dat <= r_mem[w_index];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        r_index    <= w_in_index;
                        r_in_range <= w_in_range_in;
                        r_we       <= i_wb_we;
                        r_sel      <= i_wb_sel;
                        r_dat      <= i_wb_dat;
                        o_busy     <= 1'b1;
                        if (c_NO_WAIT) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!i_wb_cyc) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: r_state <= S_GAP;
                S_GAP: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_a25_wb_sram_slave.sv
// ============================================================================
// Module   : tb_a25_wb_sram_slave
// Purpose  : Directed bench for a25_wb_sram_slave (0 and 3 wait states).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_a25_wb_sram_slave;

    localparam logic [127:0] c_A5  = {16{8'hA5}};
    localparam logic [127:0] c_P   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] c_X   = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [127:0] c_Y   = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [127:0] c_LOW = 128'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic         we;
    logic [127:0] dat;
    logic         cyc0, cyc1, stb;
    logic [127:0] dat0, dat1;
    logic         ack0, err0, busy0, ack1, err1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    a25_wb_sram_slave #(.WB_DWIDTH(128), .WB_SWIDTH(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .quick_n_reset(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(dat), .i_wb_cyc(cyc0), .i_wb_stb(stb), .o_wb_dat(dat0), .o_wb_ack(ack0),
        .o_wb_err(err0), .o_busy(busy0));

    a25_wb_sram_slave #(.WB_DWIDTH(128), .WB_SWIDTH(16), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_dut1 (
        .i_clk(clk), .quick_n_reset(rst_n), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(dat), .i_wb_cyc(cyc1), .i_wb_stb(stb), .o_wb_dat(dat1), .o_wb_ack(ack1),
        .o_wb_err(err1), .o_busy(busy1));

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [15:0]  s;
        logic [127:0] d;
        bit           exp_err;
        logic [127:0] exp_dat;
    } vec_t;

    vec_t         vecs[12];
    logic [127:0] bd[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic present(input int d, input bit w, input logic [31:0] a,
                           input logic [15:0] s, input logic [127:0] dv);
        repeat (3) @(negedge clk);
        we = w; adr = a; sel = s; dat = dv; stb = 1'b1;
        if (d == 1) cyc1 = 1'b1; else cyc0 = 1'b1;
    endtask

    task automatic release_bus();
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
    endtask

    // Single transfer; lat = cycle of first ack/err after presentation, -1 if none.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [15:0] s,
                        input logic [127:0] dv, output int lat, output logic ka, output logic ke);
        lat = -1; ka = 1'b0; ke = 1'b0;
        present(d, w, a, s, dv);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            ka = (d == 1) ? ack1 : ack0;
            ke = (d == 1) ? err1 : err0;
            if (ka || ke) begin
                lat = c;
                break;
            end
        end
        release_bus();
    endtask

    task automatic burst(input bit w);
        int beat = 0;
        repeat (3) @(negedge clk);
        we = w; adr = 32'h100; sel = 16'hFFFF; dat = bd[0]; stb = 1'b1; cyc0 = 1'b1;
        for (int c = 1; c <= 20 && beat < 4; c++) begin
            @(negedge clk);
            if (ack0) begin
                check(w ? "wburst_ack_cycle" : "rburst_ack_cycle", c, 3 * beat + 1);
                if (!w) check("rburst_data", dat0, bd[beat]);
                beat++;
                adr = 32'h100 + 32'(beat * 16);
                dat = bd[beat % 4];
            end
        end
        check("burst_beats", beat, 4);
        release_bus();
    endtask

    initial begin
        int   lat;
        logic ka, ke;
        int   nresp;

        vecs[0]  = '{1'b1, 32'h10,     16'hFFFF, 128'h0,   1'b0, 128'h0};
        vecs[1]  = '{1'b1, 32'h50,     16'hFFFF, c_A5,     1'b0, 128'h0};
        vecs[2]  = '{1'b1, 32'h10,     16'h000F, '1,       1'b0, 128'h0};
        vecs[3]  = '{1'b0, 32'h10,     16'h0,    128'h0,   1'b0, c_LOW};
        vecs[4]  = '{1'b0, 32'h50,     16'h0,    128'h0,   1'b0, c_A5};
        vecs[5]  = '{1'b0, 32'h5C,     16'h0,    128'h0,   1'b0, c_A5};
        vecs[6]  = '{1'b0, 32'h1_0000, 16'h0,    128'h0,   1'b1, c_A5};
        vecs[7]  = '{1'b1, 32'h1_0050, 16'hFFFF, 128'h0,   1'b1, c_A5};
        vecs[8]  = '{1'b0, 32'h50,     16'h0,    128'h0,   1'b0, c_A5};
        vecs[9]  = '{1'b1, 32'h3FF0,   16'hFFFF, c_P,      1'b0, c_A5};
        vecs[10] = '{1'b0, 32'h3FF0,   16'h0,    128'h0,   1'b0, c_P};
        vecs[11] = '{1'b0, 32'h4000,   16'h0,    128'h0,   1'b1, c_P};
        for (int k = 0; k < 4; k++) bd[k] = {4{32'(k + 1) * 32'h1111_1111}};

        rst_n = 1'b0; adr = '0; sel = '0; we = 1'b0; dat = '0;
        cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack", ack0, 1'b0);
        check("reset_err", err0, 1'b0);
        check("reset_busy", busy0, 1'b0);
        check("reset_dat", dat0, 128'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            xfer(0, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, lat, ka, ke);
            check($sformatf("vec%0d_lat", i), lat, 1);
            check($sformatf("vec%0d_ack", i), ka, !vecs[i].exp_err);
            check($sformatf("vec%0d_err", i), ke, vecs[i].exp_err);
            check($sformatf("vec%0d_dat", i), dat0, vecs[i].exp_dat);
        end

        // Cycle-accurate single read, zero wait states.
        present(0, 1'b0, 32'h50, 16'h0, 128'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("ws0_ack_c%0d", c), ack0, c == 1);
            check($sformatf("ws0_busy_c%0d", c), busy0, (c == 1 || c == 2));
            if (c == 1) begin
                check("ws0_rdata", dat0, c_A5);
                release_bus();
            end
        end

        burst(1'b1);
        burst(1'b0);

        // Three wait states: preload, then cycle-accurate read.
        xfer(1, 1'b1, 32'h20, 16'hFFFF, c_X, lat, ka, ke);
        check("ws3_wr_lat", lat, 4);
        present(1, 1'b0, 32'h20, 16'h0, 128'h0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("ws3_ack_c%0d", c), ack1, c == 4);
            check($sformatf("ws3_busy_c%0d", c), busy1, (c >= 1 && c <= 5));
            if (c == 4) begin
                check("ws3_rdata", dat1, c_X);
                release_bus();
            end
        end

        // Abort a write by dropping cyc while waiting.
        present(1, 1'b1, 32'h20, 16'hFFFF, c_Y);
        nresp = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ack1 || err1) nresp++;
            if (c == 2) release_bus();
            if (c == 3) check("abort_busy_low", busy1, 1'b0);
        end
        check("abort_no_resp", nresp, 0);
        xfer(1, 1'b0, 32'h20, 16'h0, 128'h0, lat, ka, ke);
        check("abort_array_kept", dat1, c_X);

        // Reset while a write is waiting.
        present(1, 1'b1, 32'h20, 16'hFFFF, c_Y);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dat", dat1, 128'h0);
        check("rst_mid_busy", busy1, 1'b0);
        check("rst_mid_ack", ack1, 1'b0);
        release_bus();
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h20, 16'h0, 128'h0, lat, ka, ke);
        check("rst_after_lat", lat, 4);
        check("rst_after_ack", ka, 1'b1);
        check("rst_after_data", dat1, c_X);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
